netwalk_execution_engine_core: RTL and testbench

NETWALK_EXECUTION_ENGINE_CORE -- requirements
Module: netwalk_execution_engine_core

---
 rtl/netwalk_exec_pkg.sv | 72 +++++++
 rtl/netwalk_field_writer.sv | 29 ++
 rtl/netwalk_execution_engine_core.sv | 87 ++++++++
 tb/tb_netwalk_execution_engine_core.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/netwalk_exec_pkg.sv
// Shared constants for the netwalk execution engine: header/action widths,
// flag indices and the packed set-field layout (width and offset per field).
package netwalk_exec_pkg;

    localparam int HDR_W      = 512;
    localparam int SET_W      = 356;
    localparam int FLAG_W     = 16;
    localparam int ADDR_W     = 9;
    localparam int NUM_FIELDS = 15;

    typedef enum logic [3:0] {
        FLD_INGRESS_PORT  = 4'd0,
        FLD_META_DATA     = 4'd1,
        FLD_DST_MAC       = 4'd2,
        FLD_SRC_MAC       = 4'd3,
        FLD_ETHER_TYPE    = 4'd4,
        FLD_VLAN_ID       = 4'd5,
        FLD_VLAN_PRIORITY = 4'd6,
        FLD_MPLS_LABEL    = 4'd7,
        FLD_MPLS_FEC      = 4'd8,
        FLD_SRC_IPV4      = 4'd9,
        FLD_DST_IPV4      = 4'd10,
        FLD_IP_PROTOCOL   = 4'd11,
        FLD_IPV4_TOS      = 4'd12,
        FLD_TCP_SRC_PORT  = 4'd13,
        FLD_TCP_DST_PORT  = 4'd14,
        FLD_DROP          = 4'd15
    } field_idx_e;

    function automatic int field_width(input int idx);
        case (idx)
            0:       return 32;
            1:       return 64;
            2:       return 48;
            3:       return 48;
            4:       return 16;
            5:       return 12;
            6:       return 3;
            7:       return 20;
            8:       return 3;
            9:       return 32;
            10:      return 32;
            11:      return 8;
            12:      return 6;
            13:      return 16;
            14:      return 16;
            default: return 1;
        endcase
    endfunction

    function automatic int set_offset(input int idx);
        case (idx)
            0:       return 0;
            1:       return 32;
            2:       return 96;
            3:       return 144;
            4:       return 192;
            5:       return 208;
            6:       return 220;
            7:       return 223;
            8:       return 243;
            9:       return 246;
            10:      return 278;
            11:      return 310;
            12:      return 318;
            13:      return 324;
            14:      return 340;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/netwalk_field_writer.sv
// Masked insert of a W-bit value into the header at a bit offset; bits that
// would land above the top of the header are dropped by the fixed-width shift.
module netwalk_field_writer
    import netwalk_exec_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [HDR_W-1:0]  hdr_in,
    input  logic [W-1:0]      value,
    input  logic [ADDR_W-1:0] offset,
    input  logic              en,
    output logic [HDR_W-1:0]  hdr_out
);

    logic [HDR_W-1:0] mask_s;
    logic [HDR_W-1:0] data_s;

    // Build the positioned mask/data and splice them into the header
    always_comb begin
        mask_s = {{(HDR_W-W){1'b0}}, {W{1'b1}}} << offset;
        data_s = {{(HDR_W-W){1'b0}}, value} << offset;
        if (en) begin
            hdr_out = (hdr_in & ~mask_s) | (data_s & mask_s);
        end else begin
            hdr_out = hdr_in;
        end
    end

endmodule

// File: rtl/netwalk_execution_engine_core.sv
// Set-field execution engine: a chain of 15 field writers rewrites the header
// in ascending field order, followed by a single output register stage.
module netwalk_execution_engine_core
    import netwalk_exec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [HDR_W-1:0]  pkt_header_in,
    input  logic [FLAG_W-1:0] exec_action_flag,
    input  logic [SET_W-1:0]  exec_action_set,
    input  logic              exec_action_enable,
    input  logic [ADDR_W-1:0] OF_INGRESS_PORT_ADDR,
    input  logic [ADDR_W-1:0] OF_META_DATA_ADDR,
    input  logic [ADDR_W-1:0] OF_DST_MAC_ADDR_ADDR,
    input  logic [ADDR_W-1:0] OF_SRC_MAC_ADDR_ADDR,
    input  logic [ADDR_W-1:0] OF_ETHER_TYPE_ADDR,
    input  logic [ADDR_W-1:0] OF_VLAN_ID_ADDR,
    input  logic [ADDR_W-1:0] OF_VLAN_PRIORITY_ADDR,
    input  logic [ADDR_W-1:0] OF_MPLS_LABEL_ADDR,
    input  logic [ADDR_W-1:0] OF_MPLS_FEC_CLASS_ADDR,
    input  logic [ADDR_W-1:0] OF_SRC_IPV4_ADDR_ADDR,
    input  logic [ADDR_W-1:0] OF_DST_IPV4_ADDR_ADDR,
    input  logic [ADDR_W-1:0] OF_IP_PROTOCOL_ADDR,
    input  logic [ADDR_W-1:0] OF_IPV4_TOS_ADDR,
    input  logic [ADDR_W-1:0] OF_TCP_SRC_PORT_ADDR,
    input  logic [ADDR_W-1:0] OF_TCP_DST_PORT_ADDR,
    output logic [HDR_W-1:0]  pkt_header_out,
    output logic              packet_out_enable
);

    logic [ADDR_W-1:0] addr_s  [NUM_FIELDS];
    logic [HDR_W-1:0]  stage_s [NUM_FIELDS+1];
    logic [HDR_W-1:0]  pkt_header_r;
    logic              out_en_r;

    // Gather the per-field offsets into an array indexed by flag bit
    always_comb begin
        addr_s[FLD_INGRESS_PORT]  = OF_INGRESS_PORT_ADDR;
        addr_s[FLD_META_DATA]     = OF_META_DATA_ADDR;
        addr_s[FLD_DST_MAC]       = OF_DST_MAC_ADDR_ADDR;
        addr_s[FLD_SRC_MAC]       = OF_SRC_MAC_ADDR_ADDR;
        addr_s[FLD_ETHER_TYPE]    = OF_ETHER_TYPE_ADDR;
        addr_s[FLD_VLAN_ID]       = OF_VLAN_ID_ADDR;
        addr_s[FLD_VLAN_PRIORITY] = OF_VLAN_PRIORITY_ADDR;
        addr_s[FLD_MPLS_LABEL]    = OF_MPLS_LABEL_ADDR;
        addr_s[FLD_MPLS_FEC]      = OF_MPLS_FEC_CLASS_ADDR;
        addr_s[FLD_SRC_IPV4]      = OF_SRC_IPV4_ADDR_ADDR;
        addr_s[FLD_DST_IPV4]      = OF_DST_IPV4_ADDR_ADDR;
        addr_s[FLD_IP_PROTOCOL]   = OF_IP_PROTOCOL_ADDR;
        addr_s[FLD_IPV4_TOS]      = OF_IPV4_TOS_ADDR;
        addr_s[FLD_TCP_SRC_PORT]  = OF_TCP_SRC_PORT_ADDR;
        addr_s[FLD_TCP_DST_PORT]  = OF_TCP_DST_PORT_ADDR;
    end

    assign stage_s[0] = pkt_header_in;

    // Later stages overwrite earlier ones, so the highest enabled index wins
    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
        netwalk_field_writer #(
            .W (field_width(i))
        ) u_writer (
            .hdr_in  (stage_s[i]),
            .value   (exec_action_set[set_offset(i) +: field_width(i)]),
            .offset  (addr_s[i]),
            .en      (exec_action_flag[i]),
            .hdr_out (stage_s[i+1])
        );
    end

    // Output register: load on enable, hold header and clear valid otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_header_r <= {HDR_W{1'b0}};
            out_en_r     <= 1'b0;
        end else if (exec_action_enable) begin
            pkt_header_r <= stage_s[NUM_FIELDS];
            out_en_r     <= ~exec_action_flag[FLD_DROP];
        end else begin
            pkt_header_r <= pkt_header_r;
            out_en_r     <= 1'b0;
        end
    end

    assign pkt_header_out    = pkt_header_r;
    assign packet_out_enable = out_en_r;

endmodule

// File: tb/tb_netwalk_execution_engine_core.sv
// Self-checking bench: directed vector table, multi-cycle reset/streaming
// sequences, and randomized traffic against a bit-level reference model.
module tb_netwalk_execution_engine_core;

    logic              clk;
    logic              reset;
    logic [511:0]      hdr_in;
    logic [15:0]       flag;
    logic [355:0]      set_v;
    logic              en;
    logic [14:0][8:0]  addr;
    logic [511:0]      hdr_out;
    logic              oe;

    int tests_run;
    int tests_failed;

    // Field layout written out independently from the action-set table
    int fw [15] = '{32, 64, 48, 48, 16, 12, 3, 20, 3, 32, 32, 8, 6, 16, 16};
    int fo [15] = '{0, 32, 96, 144, 192, 208, 220, 223, 243, 246, 278, 310, 318, 324, 340};

    typedef struct {
        logic [511:0]     hdr;
        logic [15:0]      flag;
        logic [355:0]     set;
        logic [14:0][8:0] addr;
        logic [511:0]     exp_hdr;
        logic             exp_oe;
    } vec_t;

    vec_t vecs [7];

    netwalk_execution_engine_core dut (
        .clk                    (clk),
        .reset                  (reset),
        .pkt_header_in          (hdr_in),
        .exec_action_flag       (flag),
        .exec_action_set        (set_v),
        .exec_action_enable     (en),
        .OF_INGRESS_PORT_ADDR   (addr[0]),
        .OF_META_DATA_ADDR      (addr[1]),
        .OF_DST_MAC_ADDR_ADDR   (addr[2]),
        .OF_SRC_MAC_ADDR_ADDR   (addr[3]),
        .OF_ETHER_TYPE_ADDR     (addr[4]),
        .OF_VLAN_ID_ADDR        (addr[5]),
        .OF_VLAN_PRIORITY_ADDR  (addr[6]),
        .OF_MPLS_LABEL_ADDR     (addr[7]),
        .OF_MPLS_FEC_CLASS_ADDR (addr[8]),
        .OF_SRC_IPV4_ADDR_ADDR  (addr[9]),
        .OF_DST_IPV4_ADDR_ADDR  (addr[10]),
        .OF_IP_PROTOCOL_ADDR    (addr[11]),
        .OF_IPV4_TOS_ADDR       (addr[12]),
        .OF_TCP_SRC_PORT_ADDR   (addr[13]),
        .OF_TCP_DST_PORT_ADDR   (addr[14]),
        .pkt_header_out         (hdr_out),
        .packet_out_enable      (oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] model(input logic [511:0] h, input logic [15:0] f,
                                           input logic [355:0] s, input logic [14:0][8:0] a);
        logic [511:0] r;
        r = h;
        for (int i = 0; i < 15; i++) begin
            if (f[i]) begin
                for (int b = 0; b < fw[i]; b++) begin
                    if (int'(a[i]) + b < 512) r[int'(a[i]) + b] = s[fo[i] + b];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [355:0] rand356();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
        return r[355:0];
    endfunction

    function automatic logic [14:0][8:0] rand_addr();
        logic [14:0][8:0] a;
        for (int i = 0; i < 15; i++) a[i] = 9'($urandom_range(0, 511));
        return a;
    endfunction

    task automatic check(input string name, input logic [511:0] exp_h, input logic exp_e);
        tests_run++;
        if (hdr_out !== exp_h || oe !== exp_e) begin
            tests_failed++;
            $display("FAIL %s: got hdr=%h oe=%b, expected hdr=%h oe=%b", name, hdr_out, oe, exp_h, exp_e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [511:0]     base;
    logic [511:0]     h [4];
    logic [511:0]     exp_h;
    logic             exp_e;
    logic [511:0]     tmp;

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        for (int i = 0; i < 16; i++) base[i*32 +: 32] = 32'hDEADBEEF ^ 32'(i);

        for (int i = 0; i < 7; i++) begin
            vecs[i].hdr    = base;
            vecs[i].flag   = 16'h0000;
            vecs[i].set    = rand356();
            vecs[i].addr   = rand_addr();
            vecs[i].exp_oe = 1'b1;
        end
        // 0: passthrough
        vecs[0].exp_hdr = base;
        // 1: dst IPv4 at offset 240
        vecs[1].flag = 16'h0400;
        vecs[1].addr[10] = 9'd240;
        vecs[1].set[309:278] = 32'hC0A80001;
        tmp = base; tmp[271:240] = 32'hC0A80001;
        vecs[1].exp_hdr = tmp;
        // 2: dst MAC at 0 overlapped by ethertype at 40
        vecs[2].flag = 16'h0014;
        vecs[2].addr[2] = 9'd0;
        vecs[2].addr[4] = 9'd40;
        vecs[2].set[143:96] = 48'h112233445566;
        vecs[2].set[207:192] = 16'h8100;
        tmp = base; tmp[39:0] = 40'h2233445566; tmp[55:40] = 16'h8100;
        vecs[2].exp_hdr = tmp;
        // 3: TCP dst port clipped at top of header
        vecs[3].flag = 16'h4000;
        vecs[3].addr[14] = 9'd504;
        vecs[3].set[355:340] = 16'hABCD;
        tmp = base; tmp[511:504] = 8'hCD;
        vecs[3].exp_hdr = tmp;
        // 4: same with drop
        vecs[4] = vecs[3];
        vecs[4].flag = 16'hC000;
        vecs[4].exp_oe = 1'b0;
        // 5: src and dst IPv4 at the same offset, dst (higher index) wins
        vecs[5].flag = 16'h0600;
        vecs[5].addr[9] = 9'd100;
        vecs[5].addr[10] = 9'd100;
        vecs[5].set[277:246] = 32'h01020304;
        vecs[5].set[309:278] = 32'hA5A55A5A;
        tmp = base; tmp[131:100] = 32'hA5A55A5A;
        vecs[5].exp_hdr = tmp;
        // 6: IP protocol at offset 511, only its LSB survives
        vecs[6].flag = 16'h0800;
        vecs[6].addr[11] = 9'd511;
        vecs[6].set[317:310] = 8'h80;
        tmp = base; tmp[511] = 1'b0;
        vecs[6].exp_hdr = tmp;

        // Reset asserted from time zero with arbitrary inputs
        reset  = 1'b0;
        hdr_in = rand512();
        flag   = 16'h0000;
        set_v  = rand356();
        addr   = rand_addr();
        en     = 1'b1;
        #3;
        check("reset_initial", 512'd0, 1'b0);
        tick();
        check("reset_edge", 512'd0, 1'b0);
        #2;
        reset = 1'b1;

        foreach (vecs[i]) begin
            hdr_in = vecs[i].hdr;
            flag   = vecs[i].flag;
            set_v  = vecs[i].set;
            addr   = vecs[i].addr;
            en     = 1'b1;
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp_hdr, vecs[i].exp_oe);
        end

        // Streaming: four back-to-back headers then idle
        flag = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            h[i]   = rand512();
            hdr_in = h[i];
            en     = 1'b1;
            tick();
            check($sformatf("stream%0d", i), h[i], 1'b1);
        end
        en     = 1'b0;
        hdr_in = rand512();
        tick();
        check("stream_idle0", h[3], 1'b0);
        tick();
        check("stream_idle1", h[3], 1'b0);

        // Reset mid-stream discards in-flight data
        en     = 1'b1;
        hdr_in = h[0];
        tick();
        check("pre_reset", h[0], 1'b1);
        hdr_in = h[1];
        #2;
        reset = 1'b0;
        #1;
        check("reset_async_mid", 512'd0, 1'b0);
        tick();
        check("reset_mid_edge", 512'd0, 1'b0);
        en = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        check("post_reset_idle", 512'd0, 1'b0);
        hdr_in = h[2];
        en     = 1'b1;
        tick();
        check("post_reset_first", h[2], 1'b1);

        // Randomized traffic against the reference model
        exp_h = h[2];
        exp_e = 1'b1;
        for (int n = 0; n < 300; n++) begin
            hdr_in = rand512();
            flag   = 16'($urandom);
            set_v  = rand356();
            addr   = rand_addr();
            en     = ($urandom_range(0, 3) != 0);
            if (en) begin
                exp_h = model(hdr_in, flag, set_v, addr);
                exp_e = ~flag[15];
            end else begin
                exp_e = 1'b0;
            end
            tick();
            check($sformatf("rand%0d", n), exp_h, exp_e);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
